// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// default frame geometry, used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_START   = 7;
    localparam int DEF_DBITS   = 8;
    localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side UART bundle: tick/line inputs and the parallel word with its strobes.
// parity_error exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if #(
    parameter int DBITS = 8
);
    logic             sample_tick;
    logic             rx;
    logic [DBITS-1:0] data_out;
    logic             data_ready;
    logic             frame_error;
`ifdef UART_RX_PARITY_EN
    logic             parity_error;
`endif

    modport master (
        input  sample_tick, rx,
`ifdef UART_RX_PARITY_EN
        output parity_error,
`endif
        output data_out, data_ready, frame_error
    );

    modport slave (
        output sample_tick, rx,
`ifdef UART_RX_PARITY_EN
        input  parity_error,
`endif
        input  data_out, data_ready, frame_error
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; both flops reset to the
// idle (high) line level so reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic i_rx,
    output logic o_rx_s
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    assign o_rx_s = r_sync;
endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver (start + DBITS LSB-first + optional even parity + stop).
// Optional parity stage and parity_error strobe: define UART_RX_PARITY_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBITS   = DEF_DBITS,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    uart_receiver_if.master  bus
);
    localparam int TW = (SB_TICK > 16) ? 5 : 4;
    localparam int BW = $clog2(DBITS);

    localparam logic [TW-1:0] MID_T  = TW'(MID_START);
    localparam logic [TW-1:0] BIT_T  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_T = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] LAST_B = BW'(DBITS - 1);

    uart_state_t      r_state;
    logic [TW-1:0]    r_tick_cnt;
    logic [BW-1:0]    r_bit_cnt;
    logic [DBITS-1:0] r_shift_reg;
    logic [DBITS-1:0] r_data_out;
    logic             r_data_ready;
    logic             r_frame_error;
    logic             w_rx_s;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bit;
    logic             r_parity_error;
`endif

    uart_rx_sync u_sync (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .i_rx       (bus.rx),
        .o_rx_s     (w_rx_s)
    );

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift_reg   <= '0;
            r_data_out    <= '0;
            r_data_ready  <= 1'b0;
            r_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit      <= 1'b0;
            r_parity_error <= 1'b0;
`endif
        end else begin
            r_data_ready  <= 1'b0;
            r_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_error <= 1'b0;
`endif
            case (r_state)
                // Start detection is not tick-gated so the half-bit count starts promptly.
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state    <= ST_START;
                        r_tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (bus.sample_tick) begin
                        if (r_tick_cnt == MID_T) begin
                            r_state    <= w_rx_s ? ST_IDLE : ST_DATA;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.sample_tick) begin
                        if (r_tick_cnt == BIT_T) begin
                            r_shift_reg <= {w_rx_s, r_shift_reg[DBITS-1:1]};
                            r_tick_cnt  <= '0;
                            r_bit_cnt   <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == LAST_B)
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bus.sample_tick) begin
                        if (r_tick_cnt == BIT_T) begin
                            r_par_bit  <= w_rx_s;
                            r_tick_cnt <= '0;
                            r_state    <= ST_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (bus.sample_tick) begin
                        if (r_tick_cnt == STOP_T) begin
                            r_state <= ST_IDLE;
                            // A low stop bit wins over everything else; the word is dropped.
                            if (w_rx_s) begin
                                r_data_out   <= r_shift_reg;
                                r_data_ready <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                r_parity_error <= ^{r_shift_reg, r_par_bit};
`endif
                            end else begin
                                r_frame_error <= 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_ready  = r_data_ready;
    assign bus.frame_error = r_frame_error;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error = r_parity_error;
`endif
endmodule
